// File: rtl/alu_issue.sv
// Decode-and-issue front end for a registered ALU: accepts RV32I OP/OP-IMM words,
// reads operands from a 32x32 register file, waits out the ALU latency and writes back.
module alu_issue #(
  parameter int ALU_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  output logic [31:0] alu_rs1,
  output logic [31:0] alu_rs2,
  output logic [2:0]  alu_funct3,
  output logic        alu_funct7,
  input  logic [31:0] alu_rd,
  input  logic        alu_z,
  output logic        wb_valid,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        wb_zero,
  output logic        illegal,
  input  logic [4:0]  dbg_raddr,
  output logic [31:0] dbg_rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_WB    = 2'd3
  } state_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;
  localparam logic [3:0] LAT_M1     = 4'(ALU_LATENCY - 1);

  state_e      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        instr_ready_q, instr_ready_d;
  logic [31:0] alu_rs1_q, alu_rs1_d;
  logic [31:0] alu_rs2_q, alu_rs2_d;
  logic [2:0]  alu_funct3_q, alu_funct3_d;
  logic        alu_funct7_q, alu_funct7_d;
  logic        wb_valid_q, wb_valid_d;
  logic [4:0]  wb_addr_q, wb_addr_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        wb_zero_q, wb_zero_d;
  logic        illegal_q, illegal_d;
  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];

  logic [6:0]  opcode_s;
  logic [4:0]  rd_s;
  logic [2:0]  funct3_s;
  logic [4:0]  rs1_s;
  logic [4:0]  rs2_s;
  logic [6:0]  funct7_s;
  logic [31:0] rs1_val_s;
  logic [31:0] rs2_val_s;
  logic        legal_s;
  logic [31:0] op_b_s;
  logic        alt_s;

  assign opcode_s  = instr_q[6:0];
  assign rd_s      = instr_q[11:7];
  assign funct3_s  = instr_q[14:12];
  assign rs1_s     = instr_q[19:15];
  assign rs2_s     = instr_q[24:20];
  assign funct7_s  = instr_q[31:25];
  assign rs1_val_s = (rs1_s == 5'd0) ? 32'd0 : regs_q[rs1_s];
  assign rs2_val_s = (rs2_s == 5'd0) ? 32'd0 : regs_q[rs2_s];

  // Decode legality, operand B and the alternate-op bit from the latched word.
  always_comb begin
    legal_s = 1'b0;
    op_b_s  = 32'd0;
    alt_s   = 1'b0;
    case (opcode_s)
      OPC_OP: begin
        legal_s = (funct7_s == F7_BASE) ||
                  ((funct7_s == F7_ALT) && ((funct3_s == 3'b000) || (funct3_s == 3'b101)));
        op_b_s  = rs2_val_s;
        alt_s   = instr_q[30];
      end
      OPC_OP_IMM: begin
        case (funct3_s)
          3'b001: begin
            legal_s = (funct7_s == F7_BASE);
            op_b_s  = {27'd0, rs2_s};
            alt_s   = 1'b0;
          end
          3'b101: begin
            legal_s = (funct7_s == F7_BASE) || (funct7_s == F7_ALT);
            op_b_s  = {27'd0, rs2_s};
            alt_s   = instr_q[30];
          end
          default: begin
            legal_s = 1'b1;
            op_b_s  = {{20{instr_q[31]}}, instr_q[31:20]};
            alt_s   = 1'b0;
          end
        endcase
      end
      default: begin
        legal_s = 1'b0;
        op_b_s  = 32'd0;
        alt_s   = 1'b0;
      end
    endcase
  end

  // Next-state logic and registered output updates for the issue sequence.
  always_comb begin
    state_d      = state_q;
    instr_d      = instr_q;
    cnt_d        = cnt_q;
    alu_rs1_d    = alu_rs1_q;
    alu_rs2_d    = alu_rs2_q;
    alu_funct3_d = alu_funct3_q;
    alu_funct7_d = alu_funct7_q;
    wb_valid_d   = 1'b0;
    wb_addr_d    = wb_addr_q;
    wb_data_d    = wb_data_q;
    wb_zero_d    = wb_zero_q;
    illegal_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (instr_valid && instr_ready_q) begin
          instr_d = instr;
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (legal_s) begin
          alu_rs1_d    = rs1_val_s;
          alu_rs2_d    = op_b_s;
          alu_funct3_d = funct3_s;
          alu_funct7_d = alt_s;
          cnt_d        = LAT_M1;
          state_d      = S_WAIT;
        end else begin
          illegal_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          wb_data_d  = alu_rd;
          wb_zero_d  = alu_z;
          wb_addr_d  = rd_s;
          wb_valid_d = 1'b1;
          state_d    = S_WB;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_WB: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    instr_ready_d = (state_d == S_IDLE);
  end

  // Register-file write port: the retiring result lands during WB; x0 stays zero.
  always_comb begin
    regs_d = regs_q;
    if ((state_q == S_WB) && (wb_addr_q != 5'd0)) begin
      regs_d[wb_addr_q] = wb_data_q;
    end else begin
      regs_d[0] = 32'd0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      instr_q       <= 32'd0;
      cnt_q         <= 4'd0;
      instr_ready_q <= 1'b1;
      alu_rs1_q     <= 32'd0;
      alu_rs2_q     <= 32'd0;
      alu_funct3_q  <= 3'd0;
      alu_funct7_q  <= 1'b0;
      wb_valid_q    <= 1'b0;
      wb_addr_q     <= 5'd0;
      wb_data_q     <= 32'd0;
      wb_zero_q     <= 1'b0;
      illegal_q     <= 1'b0;
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= 32'd0;
      end
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      cnt_q         <= cnt_d;
      instr_ready_q <= instr_ready_d;
      alu_rs1_q     <= alu_rs1_d;
      alu_rs2_q     <= alu_rs2_d;
      alu_funct3_q  <= alu_funct3_d;
      alu_funct7_q  <= alu_funct7_d;
      wb_valid_q    <= wb_valid_d;
      wb_addr_q     <= wb_addr_d;
      wb_data_q     <= wb_data_d;
      wb_zero_q     <= wb_zero_d;
      illegal_q     <= illegal_d;
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign instr_ready = instr_ready_q;
  assign alu_rs1     = alu_rs1_q;
  assign alu_rs2     = alu_rs2_q;
  assign alu_funct3  = alu_funct3_q;
  assign alu_funct7  = alu_funct7_q;
  assign wb_valid    = wb_valid_q;
  assign wb_addr     = wb_addr_q;
  assign wb_data     = wb_data_q;
  assign wb_zero     = wb_zero_q;
  assign illegal     = illegal_q;
  assign dbg_rdata   = (dbg_raddr == 5'd0) ? 32'd0 : regs_q[dbg_raddr];

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed test-plan steps plus random OP/OP-IMM words checked
// against an instruction-level model; a second instance with ALU_LATENCY=3 covers reset.
module tb_alu_issue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, instr_valid, instr_ready, alu_funct7, alu_z, wb_valid, wb_zero, illegal;
  logic [31:0] instr, alu_rs1, alu_rs2, alu_rd, wb_data, dbg_rdata;
  logic [2:0]  alu_funct3;
  logic [4:0]  wb_addr, dbg_raddr;

  logic        rst3, instr_valid3, instr_ready3, alu_funct7_3, alu_z3, wb_valid3, wb_zero3, illegal3;
  logic [31:0] instr3, alu_rs1_3, alu_rs2_3, alu_rd3, wb_data3, dbg_rdata3;
  logic [2:0]  alu_funct3_3;
  logic [4:0]  wb_addr3, dbg_raddr3;

  int checks = 0;
  int failures = 0;
  logic [31:0] ref_regs [32];
  logic [31:0] exp_a, exp_b, last_wb_data;
  logic [2:0]  exp_f3;
  logic        exp_f7, last_wb_zero;
  logic [4:0]  last_wb_addr;

  function automatic logic [31:0] alu_fn(input logic [2:0] f3, input logic alt,
                                         input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0:    return alt ? a - b : a + b;
      3'd1:    return a << b[4:0];
      3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3:    return (a < b) ? 32'd1 : 32'd0;
      3'd4:    return a ^ b;
      3'd5:    return alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  // Behavioural ALU attached to each instance
  assign alu_rd  = alu_fn(alu_funct3, alu_funct7, alu_rs1, alu_rs2);
  assign alu_z   = (alu_rd == 32'd0);
  assign alu_rd3 = alu_fn(alu_funct3_3, alu_funct7_3, alu_rs1_3, alu_rs2_3);
  assign alu_z3  = (alu_rd3 == 32'd0);

  alu_issue #(.ALU_LATENCY(1)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_funct3(alu_funct3), .alu_funct7(alu_funct7),
    .alu_rd(alu_rd), .alu_z(alu_z), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .wb_zero(wb_zero), .illegal(illegal), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
  );

  alu_issue #(.ALU_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst3), .instr_valid(instr_valid3), .instr(instr3), .instr_ready(instr_ready3),
    .alu_rs1(alu_rs1_3), .alu_rs2(alu_rs2_3), .alu_funct3(alu_funct3_3), .alu_funct7(alu_funct7_3),
    .alu_rd(alu_rd3), .alu_z(alu_z3), .wb_valid(wb_valid3), .wb_addr(wb_addr3), .wb_data(wb_data3),
    .wb_zero(wb_zero3), .illegal(illegal3), .dbg_raddr(dbg_raddr3), .dbg_rdata(dbg_rdata3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Instruction-level view: legality, operand B and the alternate-op bit
  task automatic model(input logic [31:0] w, output logic legal, output logic [31:0] b,
                       output logic alt);
    logic [6:0] op, f7;
    logic [2:0] f3;
    op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
    legal = 1'b0; b = 32'd0; alt = 1'b0;
    if (op == 7'h33) begin
      legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      b = ref_regs[w[24:20]];
      alt = (f7 == 7'h20);
    end else if (op == 7'h13) begin
      if (f3 == 3'd1) begin
        legal = (f7 == 7'h00); b = 32'(w[24:20]);
      end else if (f3 == 3'd5) begin
        legal = (f7 == 7'h00) || (f7 == 7'h20); b = 32'(w[24:20]); alt = (f7 == 7'h20);
      end else begin
        legal = 1'b1; b = 32'($signed(w[31:20]));
      end
    end
  endtask

  task automatic run(input logic [31:0] w);
    logic legal, alt;
    logic [31:0] a, b, res;
    logic [4:0] rd;
    int kend;
    model(w, legal, b, alt);
    a   = ref_regs[w[19:15]];
    rd  = w[11:7];
    res = alu_fn(w[14:12], alt, a, b);
    if (legal) begin
      exp_a = a; exp_b = b; exp_f3 = w[14:12]; exp_f7 = alt;
    end
    check("ready_before_accept", instr_ready, 32'd1);
    instr = w; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0; instr = $urandom();
    kend = legal ? 4 : 2;
    for (int k = 1; k <= kend; k++) begin
      @(negedge clk);
      check("wb_valid", wb_valid, 32'(legal && k == 3));
      check("illegal", illegal, 32'(!legal && k == 2));
      check("instr_ready", instr_ready, 32'(legal ? (k == 4) : (k == 2)));
      if (k == 2) begin
        check("alu_rs1", alu_rs1, exp_a);
        check("alu_rs2", alu_rs2, exp_b);
        check("alu_funct3", 32'(alu_funct3), 32'(exp_f3));
        check("alu_funct7", 32'(alu_funct7), 32'(exp_f7));
      end
      if (legal && k == 3) begin
        last_wb_addr = rd; last_wb_data = res; last_wb_zero = (res == 32'd0);
      end
      check("wb_addr", 32'(wb_addr), 32'(last_wb_addr));
      check("wb_data", wb_data, last_wb_data);
      check("wb_zero", 32'(wb_zero), 32'(last_wb_zero));
    end
    if (legal && rd != 5'd0) ref_regs[rd] = res;
    dbg_raddr = rd; #1;
    check("dbg_rdata", dbg_rdata, ref_regs[rd]);
  endtask

  task automatic dbg_expect(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    dbg_raddr = addr; #1;
    check(tag, dbg_rdata, exp);
  endtask

  initial begin
    logic [6:0] op, f7;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    int sel;
    rst = 1'b1; rst3 = 1'b1;
    instr_valid = 1'b0; instr = 32'd0; dbg_raddr = 5'd0;
    instr_valid3 = 1'b0; instr3 = 32'd0; dbg_raddr3 = 5'd0;
    for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
    exp_a = 32'd0; exp_b = 32'd0; exp_f3 = 3'd0; exp_f7 = 1'b0;
    last_wb_addr = 5'd0; last_wb_data = 32'd0; last_wb_zero = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_instr_ready", instr_ready, 32'd1);
    check("rst_alu_rs1", alu_rs1, 32'd0);
    check("rst_alu_rs2", alu_rs2, 32'd0);
    check("rst_wb_valid", wb_valid, 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_illegal", illegal, 32'd0);
    rst = 1'b0; rst3 = 1'b0;
    dbg_expect("rst_dbg_x1", 5'd1, 32'd0);

    run(32'h01400093);
    run(32'h01E00113);
    dbg_expect("x1_is_20", 5'd1, 32'd20);
    dbg_expect("x2_is_30", 5'd2, 32'd30);
    run(32'h002081B3);
    dbg_expect("x3_is_50", 5'd3, 32'd50);
    run(32'h40108233);
    check("sub_wb_zero", 32'(wb_zero), 32'd1);
    check("sub_alu_funct7", 32'(alu_funct7), 32'd1);
    run(32'hFF800293);
    run(32'h4012D313);
    check("srai_alu_rs2", alu_rs2, 32'd1);
    dbg_expect("x6_sra", 5'd6, 32'hFFFFFFFC);
    run(32'h00500013);
    check("x0_wb_addr", 32'(wb_addr), 32'd0);
    dbg_expect("x0_zero", 5'd0, 32'd0);
    run(32'h0000007F);

    for (int n = 0; n < 80; n++) begin
      sel = $urandom_range(0, 9);
      rd = 5'($urandom_range(0, 7)); rs1 = 5'($urandom_range(0, 7)); rs2 = 5'($urandom());
      f3 = 3'($urandom());
      case ($urandom_range(0, 3))
        0: f7 = 7'h00;
        1: f7 = 7'h20;
        2: f7 = 7'h00;
        default: f7 = 7'($urandom());
      endcase
      if (sel < 4) begin
        op = 7'h33; rs2 = 5'($urandom_range(0, 7));
      end else if (sel < 9) begin
        op = 7'h13;
        if (f3 != 3'd1 && f3 != 3'd5) f7 = 7'($urandom());
      end else begin
        op = 7'($urandom());
      end
      run({f7, rs2, rs1, f3, rd, op});
    end

    // ALU_LATENCY=3 instance: full retire, then reset during WAIT
    instr3 = 32'h00900413; instr_valid3 = 1'b1;
    @(posedge clk); #1;
    instr_valid3 = 1'b0; instr3 = $urandom();
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check("l3_wb_valid", wb_valid3, 32'(k == 5));
      if (k == 5) check("l3_wb_data", wb_data3, 32'd9);
    end
    dbg_raddr3 = 5'd8; #1;
    check("l3_dbg_x8", dbg_rdata3, 32'd9);

    instr3 = 32'h00900393; instr_valid3 = 1'b1;
    @(posedge clk); #1;
    instr_valid3 = 1'b0;
    @(negedge clk);
    check("l3_ready_issue", instr_ready3, 32'd0);
    @(negedge clk);
    check("l3_alu_rs2_wait", alu_rs2_3, 32'd9);
    rst3 = 1'b1;
    @(negedge clk);
    check("l3_rst_ready", instr_ready3, 32'd1);
    check("l3_rst_alu_rs2", alu_rs2_3, 32'd0);
    rst3 = 1'b0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      check("l3_post_rst_wb_valid", wb_valid3, 32'd0);
      check("l3_post_rst_illegal", illegal3, 32'd0);
      check("l3_post_rst_ready", instr_ready3, 32'd1);
    end
    dbg_raddr3 = 5'd7; #1;
    check("l3_dbg_x7", dbg_rdata3, 32'd0);
    dbg_raddr3 = 5'd8; #1;
    check("l3_dbg_x8_cleared", dbg_rdata3, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
